// File: rtl/phase_seq_ctrl_pkg.sv
// Shared definitions for the programmable phase sequencer: phase codes,
// FSM states, config register map and power-up phase lengths.
package phase_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_A    = 2'd1,
        S_B    = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_A    = 2'd1;
    localparam logic [1:0] PH_B    = 2'd2;

    localparam logic [1:0] ADDR_LEN_A    = 2'd0;
    localparam logic [1:0] ADDR_LEN_B    = 2'd1;
    localparam logic [1:0] ADDR_LEN_GAP  = 2'd2;
    localparam logic [1:0] ADDR_NFRAMES  = 2'd3;

    localparam int DEF_LEN_A   = 4;
    localparam int DEF_LEN_B   = 3;
    localparam int DEF_LEN_GAP = 1;

    // GAP shares code 0 with IDLE so downstream logic sees "no phase".
    function automatic logic [1:0] phase_code(input state_t s);
        logic [1:0] c;
        c = PH_IDLE;
        case (s)
            S_A:     c = PH_A;
            S_B:     c = PH_B;
            default: c = PH_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_seq_ctrl_if.sv
// Config/control bus between the control plane and the phase sequencer,
// plus the sequencer's status outputs.
interface phase_seq_ctrl_if #(
    parameter int FW = 8
) ();
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [FW-1:0] cfg_wdata;
    logic          start;
    logic          stop;
    logic [1:0]    phase_o;
    logic          busy;
    logic          frame_tick;
    logic          done;
    logic [FW-1:0] frame_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, stop,
        input  phase_o, busy, frame_tick, done, frame_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, stop,
        output phase_o, busy, frame_tick, done, frame_cnt
    );
endinterface

// File: rtl/phase_seq_ctrl_len_cnt.sv
// Loadable down-counter timing one phase; reloaded with length-1 on every
// phase change and holding at zero until the next load.
module phase_len_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero,
    output logic          one
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CW'(1));
endmodule

// File: rtl/phase_seq_ctrl.sv
// Programmable A/B/GAP phase sequencer with shadowed configuration, frame
// counting and a start/stop/done handshake.
module phase_seq_ctrl
    import phase_pkg::*;
#(
    parameter int CW = 4,
    parameter int FW = 8
) (
    input  logic             clk,
    input  logic             rstb,
    phase_seq_ctrl_if.slave  bus
);
    state_t        state, state_nxt;
    logic [CW-1:0] sh_len_a, sh_len_b, sh_len_gap;
    logic [CW-1:0] len_a, len_b, len_gap;
    logic [FW-1:0] sh_nframes, nframes;
    logic          stop_pend;
    logic          cnt_load, cnt_zero, cnt_one;
    logic [CW-1:0] cnt_load_val;
    logic          start_go, frame_end, run_end, tick_nxt;

    // A zero length would make the phase vanish; clamp it to one cycle.
    function automatic logic [CW-1:0] fix_len(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    phase_len_cnt #(.CW(CW)) u_len_cnt (
        .clk      (clk),
        .rstb     (rstb),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    assign start_go  = (state == S_IDLE) && bus.start;
    assign frame_end = (state == S_GAP) && cnt_zero;
    // frame_cnt already includes the frame ending now, since it steps with frame_tick.
    assign run_end   = frame_end &&
                       (stop_pend || bus.stop ||
                        ((nframes != '0) && (bus.frame_cnt == nframes)));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            S_IDLE: if (bus.start) begin
                state_nxt    = S_A;
                cnt_load     = 1'b1;
                cnt_load_val = sh_len_a - CW'(1);
            end
            S_A: if (cnt_zero) begin
                state_nxt    = S_B;
                cnt_load     = 1'b1;
                cnt_load_val = len_b - CW'(1);
            end
            S_B: if (cnt_zero) begin
                state_nxt    = S_GAP;
                cnt_load     = 1'b1;
                cnt_load_val = len_gap - CW'(1);
            end
            S_GAP: if (cnt_zero) begin
                if (run_end) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt    = S_A;
                    cnt_load     = 1'b1;
                    cnt_load_val = sh_len_a - CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next cycle is the last GAP cycle: either a 1-cycle GAP starts, or the counter is about to hit 0.
    assign tick_nxt = ((state == S_B) && cnt_zero && (len_gap == CW'(1))) ||
                      ((state == S_GAP) && cnt_one);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bus.phase_o    <= PH_IDLE;
            bus.busy       <= 1'b0;
            bus.frame_tick <= 1'b0;
            bus.done       <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            bus.phase_o    <= phase_code(state_nxt);
            bus.busy       <= (state_nxt != S_IDLE);
            bus.frame_tick <= tick_nxt;
            bus.done       <= run_end;
            if (start_go)
                bus.frame_cnt <= '0;
            else if (tick_nxt && (bus.frame_cnt != '1))
                bus.frame_cnt <= bus.frame_cnt + FW'(1);
        end
    end

    // A stop seen together with start still lets exactly one frame run.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                             stop_pend <= 1'b0;
        else if (start_go)                     stop_pend <= bus.stop;
        else if (run_end)                      stop_pend <= 1'b0;
        else if (state != S_IDLE && bus.stop)  stop_pend <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sh_len_a   <= CW'(DEF_LEN_A);
            sh_len_b   <= CW'(DEF_LEN_B);
            sh_len_gap <= CW'(DEF_LEN_GAP);
            sh_nframes <= '0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_LEN_A:   sh_len_a   <= fix_len(bus.cfg_wdata[CW-1:0]);
                ADDR_LEN_B:   sh_len_b   <= fix_len(bus.cfg_wdata[CW-1:0]);
                ADDR_LEN_GAP: sh_len_gap <= fix_len(bus.cfg_wdata[CW-1:0]);
                default:      sh_nframes <= bus.cfg_wdata;
            endcase
        end
    end

    // Active settings change only at frame starts so a frame is never altered mid-flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            len_a   <= CW'(DEF_LEN_A);
            len_b   <= CW'(DEF_LEN_B);
            len_gap <= CW'(DEF_LEN_GAP);
            nframes <= '0;
        end else if (start_go || (frame_end && !run_end)) begin
            len_a   <= sh_len_a;
            len_b   <= sh_len_b;
            len_gap <= sh_len_gap;
            nframes <= sh_nframes;
        end
    end

    // len_a is the active copy; the counter loads A straight from the shadow at the frame start.
    logic unused_len_a;
    assign unused_len_a = ^len_a;
endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed bench for phase_seq_ctrl: hand-computed phase sequences, frame
// ticks, done pulses and frame counts across config, stop and reset cases.
module tb_phase_seq_ctrl;
    import phase_pkg::*;

    localparam int CW = 4;
    localparam int FW = 8;

    logic clk = 1'b0;
    logic rstb;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    phase_seq_ctrl_if #(.FW(FW)) bus ();

    phase_seq_ctrl #(.CW(CW), .FW(FW)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse_start(input logic with_stop);
        bus.start = 1'b1;
        bus.stop  = with_stop;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // Checks one frame cycle by cycle; kind: 1 stop, 2 start, 3 write LEN_B=6, 4 write LEN_GAP=0.
    task automatic expect_frame(input string tag, input int la, input int lb, input int lg,
                                input int fc, input int pulse_at, input int kind);
        int total;
        logic [1:0] ph;
        total = la + lb + lg;
        for (int i = 0; i < total; i++) begin
            ph = (i < la) ? PH_A : ((i < la + lb) ? PH_B : PH_IDLE);
            check({tag, "/phase"}, 32'(bus.phase_o), 32'(ph));
            check({tag, "/busy"}, 32'(bus.busy), 32'd1);
            check({tag, "/tick"}, 32'(bus.frame_tick), 32'(i == total - 1));
            check({tag, "/done"}, 32'(bus.done), 32'd0);
            if (i == total - 1)
                check({tag, "/frame_cnt"}, 32'(bus.frame_cnt), 32'(fc));
            if (i == pulse_at) begin
                case (kind)
                    1: bus.stop = 1'b1;
                    2: bus.start = 1'b1;
                    3: begin bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_LEN_B;   bus.cfg_wdata = 8'd6; end
                    default: begin bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_LEN_GAP; bus.cfg_wdata = 8'd0; end
                endcase
            end
            step();
            bus.stop   = 1'b0;
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
        end
    endtask

    task automatic expect_done(input string tag, input int fc);
        check({tag, "/done_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "/done"}, 32'(bus.done), 32'd1);
        check({tag, "/done_phase"}, 32'(bus.phase_o), 32'(PH_IDLE));
        check({tag, "/done_tick"}, 32'(bus.frame_tick), 32'd0);
        check({tag, "/done_frame_cnt"}, 32'(bus.frame_cnt), 32'(fc));
        step();
        check({tag, "/done_clear"}, 32'(bus.done), 32'd0);
        check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rstb          = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        #12;
        check("rst/phase", 32'(bus.phase_o), 32'd0);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/tick", 32'(bus.frame_tick), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/frame_cnt", 32'(bus.frame_cnt), 32'd0);
        step();
        rstb = 1'b1;
        step();
        check("idle/phase", 32'(bus.phase_o), 32'd0);

        // Defaults, two frames.
        cfg_write(ADDR_NFRAMES, 8'd2);
        pulse_start(1'b0);
        expect_frame("t1f1", 4, 3, 1, 1, -1, 0);
        expect_frame("t1f2", 4, 3, 1, 2, -1, 0);
        expect_done("t1", 2);

        // Programmed lengths, one frame.
        cfg_write(ADDR_LEN_A, 8'd2);
        cfg_write(ADDR_LEN_B, 8'd5);
        cfg_write(ADDR_LEN_GAP, 8'd3);
        cfg_write(ADDR_NFRAMES, 8'd1);
        pulse_start(1'b0);
        expect_frame("t2f1", 2, 5, 3, 1, -1, 0);
        expect_done("t2", 1);

        // Free run, stop in the 3rd cycle of frame 2.
        cfg_write(ADDR_LEN_A, 8'd4);
        cfg_write(ADDR_LEN_B, 8'd3);
        cfg_write(ADDR_LEN_GAP, 8'd1);
        cfg_write(ADDR_NFRAMES, 8'd0);
        pulse_start(1'b0);
        expect_frame("t3f1", 4, 3, 1, 1, -1, 0);
        expect_frame("t3f2", 4, 3, 1, 2, 2, 1);
        expect_done("t3", 2);

        // Mid-run writes only apply from the next frame; GAP=0 becomes 1.
        cfg_write(ADDR_LEN_GAP, 8'd3);
        pulse_start(1'b0);
        expect_frame("t4f1", 4, 3, 3, 1, 1, 3);
        expect_frame("t4f2", 4, 6, 3, 2, 2, 4);
        expect_frame("t4f3", 4, 6, 1, 3, 0, 1);
        expect_done("t4", 3);

        // start+stop together, then start while busy.
        cfg_write(ADDR_LEN_B, 8'd3);
        pulse_start(1'b1);
        expect_frame("t5f1", 4, 3, 1, 1, -1, 0);
        expect_done("t5a", 1);
        cfg_write(ADDR_NFRAMES, 8'd1);
        pulse_start(1'b0);
        expect_frame("t5f2", 4, 3, 1, 1, 5, 2);
        expect_done("t5b", 1);

        // Asynchronous reset in the middle of phase B.
        cfg_write(ADDR_LEN_A, 8'd2);
        cfg_write(ADDR_NFRAMES, 8'd0);
        pulse_start(1'b0);
        check("t6/a0", 32'(bus.phase_o), 32'(PH_A));
        step();
        check("t6/a1", 32'(bus.phase_o), 32'(PH_A));
        step();
        check("t6/b0", 32'(bus.phase_o), 32'(PH_B));
        #2;
        rstb = 1'b0;
        #1;
        check("t6/rst_phase", 32'(bus.phase_o), 32'd0);
        check("t6/rst_busy", 32'(bus.busy), 32'd0);
        check("t6/rst_tick", 32'(bus.frame_tick), 32'd0);
        check("t6/rst_done", 32'(bus.done), 32'd0);
        check("t6/rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        step();
        rstb = 1'b1;
        step();
        check("t6/post_done", 32'(bus.done), 32'd0);
        check("t6/post_busy", 32'(bus.busy), 32'd0);
        cfg_write(ADDR_NFRAMES, 8'd1);
        pulse_start(1'b0);
        expect_frame("t6f1", 4, 3, 1, 1, -1, 0);
        expect_done("t6", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/phase_seq_ctrl.md
# phase_seq_ctrl

Programmable phase sequencer that drives a 2-bit phase code through repeating frames of three phases: A (code 1), B (code 2) and GAP (code 0). It generalises the fixed 4/3/1 eight-cycle phase counter used in the datapath. Phase lengths and frame count are register-programmable, and a start/stop/done handshake is provided. It sits between the control/config bus and the phase-consuming datapath.

## Interface
- CW, 4: width of the phase-length counters; max phase length 2^CW−1.
- FW, 8: width of the frame-count register and frame counter.

- clk  in  1  clock, rising edge.
- rstb  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_addr  in  2  0=LEN_A, 1=LEN_B, 2=LEN_GAP, 3=NFRAMES.
- cfg_wdata  in  FW  write data; length registers take bits [CW-1:0].
- start  in  1  run request, pulse.
- stop  in  1  graceful stop request, pulse.
- phase_o  out  2  registered phase code: 0 in IDLE/GAP, 1 in A, 2 in B.
- busy  out  1  high from the first A cycle through the last GAP cycle.
- frame_tick  out  1  one-cycle pulse on the last GAP cycle of every frame.
- done  out  1  one-cycle pulse on the first IDLE cycle after a run ends.
- frame_cnt  out  FW  completed frames in the current run; saturates at all-ones.

## Operation
- Reset values:
  - phase_o=0, busy=0, frame_tick=0, done=0, frame_cnt=0, state IDLE.
  - LEN_A=4, LEN_B=3, LEN_GAP=1, NFRAMES=0.
- Length writes of 0 are stored as 1; no phase is ever skipped.
- NFRAMES=0 means free-run until stop.
- States and transitions:
  - IDLE → A on start.
  - A → B after LEN_A cycles.
  - B → GAP after LEN_B cycles.
  - GAP → A after LEN_GAP cycles, or GAP → IDLE if the run ends.
- A run ends at a frame boundary when either:
  - stop is pending, or
  - NFRAMES≠0 and the completed-frame count equals NFRAMES.
- Config writes go to shadow registers. Active lengths and NFRAMES are copied from the shadows on start and at every GAP→A transition, so no frame is ever altered mid-flight.
- stop is latched into stop_pend. It is cleared on return to IDLE and on start.
- A start pulse while busy is ignored.
- start and stop in the same IDLE cycle: the run starts and exactly one frame executes.
- A stop pulse in IDLE (without start) has no effect.
- frame_cnt clears on start and increments together with frame_tick.
- Phase-length counter: counts down from length−1 to 0; phase changes on the cycle after it reaches 0.

## Timing
- start sampled at edge N: at edge N+1, phase_o=1 and busy=1.
- With defaults, each frame is 8 cycles: phase_o sequence 1,1,1,1,2,2,2,0.
- Frame length is LEN_A+LEN_B+LEN_GAP cycles.
- frame_tick is coincident with the last GAP cycle.
- On run end:
  - the cycle after the last GAP: busy=0, done=1, phase_o=0;
  - done deasserts the following cycle.
- A start pulse arriving on the done cycle is accepted; A begins on the next cycle.
- A stop pulse arriving in the last GAP cycle takes effect at that same boundary.
- Reset asserted mid-run:
  - all outputs go to their reset values immediately (asynchronous);
  - shadow and active config return to defaults;
  - no done pulse is generated.

## Structure
- Shared package phase_pkg holds:
  - phase-code constants PH_IDLE=0, PH_A=1, PH_B=2;
  - the state enum;
  - config address constants;
  - default lengths 4/3/1.
- Natural sub-module: phase_len_cnt, a loadable CW-bit down-counter with a load value and a zero flag, instanced once and reloaded at each phase change.

## Test plan
- Defaults, start, NFRAMES=2 → phase_o 1×4, 2×3, 0×1, repeated twice; frame_tick at cycles 8 and 16; done at cycle 17; frame_cnt=2.
- LEN_A=2, LEN_B=5, LEN_GAP=3, NFRAMES=1 → phase_o 1,1,2,2,2,2,2,0,0,0, then done.
- Free-run with stop pulsed in the 3rd cycle of frame 2 → frame 2 completes; done follows; frame_cnt=2.
- LEN_B written 6 during frame 1 of a free run → frame 1 keeps B=3; frame 2 uses B=6. A write of 0 to LEN_GAP → GAP lasts 1 cycle.
- start+stop in the same IDLE cycle → exactly one 8-cycle frame, then done. A start pulse during busy → no effect.
- rstb low in the middle of phase B → all outputs 0 immediately, no done. After release, start → default 8-cycle frame.
